modulation_az_seq: RTL and testbench

Parametrised auto-zero modulation sequencer for the DMM front end. It drives the precharge switch and the AZ lo-mux through repeating signal and zero sample windows. Compared with the fixed-timing AZ controller it adds:
- runtime-programmable precharge and sample durations;
- a mode select (no-AZ or AZ);
- a run/stop handshake that stops only at a cycle boundary;
- per-window completion strobes and a completed-cycle counter for the ADC/readout logic.

---
 rtl/modulation_az_seq.sv | 258 +++++++++++++++++++++++++
 tb/tb_modulation_az_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/modulation_az_seq.sv
// modulation_az_seq
// Auto-zero modulation sequencer for the DMM front end. It steps the
// precharge switch and the AZ lo-mux through repeating signal and zero
// sample windows. Durations, mode and the zero-sample mux code are latched
// when the sequencer leaves IDLE and again at every cycle boundary.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   run           level: 1 keep cycling, 0 stop at the next cycle boundary
//   mode          00 idle, 01 NO_AZ, 10 AZ, 11 idle
//   precharge_n   precharge/settle phase length in clocks (0 acts as 1)
//   sample_n      sample window length in clocks (0 acts as 1)
//   az_mux_val    lo-mux code used during the zero sample
//   sw_pc_ctl     precharge switch, 1 = SIGNAL, 0 = BOOT
//   azmux         AZ mux code
//   sample_active high throughout any sample window
//   sample_is_sig 1 = current/last window is signal, 0 = lo
//   sample_done   one-clock pulse on the last clock of each sample window
//   busy          sequencer is not idle
//   cycle_count   completed cycles, wraps
//   led0          toggles per completed cycle
//   monitor       {busy, state[2:0], sample_done, sw_pc_ctl, lo win, sig win}
//
// Handshake: run is a plain level, not a valid/ready pair. It is sampled
// only when leaving IDLE and at a cycle boundary; dropping it never
// shortens a phase.
module modulation_az_seq #(
  parameter int                CNT_W      = 24,
  parameter int                MUX_W      = 4,
  parameter logic [MUX_W-1:0]  PC_MUX_VAL = 4'b1000,
  parameter int                CYC_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] precharge_n,
  input  logic [CNT_W-1:0] sample_n,
  input  logic [MUX_W-1:0] az_mux_val,
  output logic             sw_pc_ctl,
  output logic [MUX_W-1:0] azmux,
  output logic             sample_active,
  output logic             sample_is_sig,
  output logic             sample_done,
  output logic             busy,
  output logic [CYC_W-1:0] cycle_count,
  output logic             led0,
  output logic [7:0]       monitor
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PC_BOOT    = 3'd1,
    SAMPLE_SIG = 3'd2,
    PC_RESTORE = 3'd3,
    SAMPLE_LO  = 3'd4
  } state_t;

  localparam logic [1:0] MODE_NO_AZ = 2'b01;
  localparam logic [1:0] MODE_AZ    = 2'b10;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] pn_q, pn_d;
  logic [CNT_W-1:0] sn_q, sn_d;
  logic [MUX_W-1:0] azv_q, azv_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             led_q, led_d;

  logic             sw_q, sw_d;
  logic [MUX_W-1:0] azmux_q, azmux_d;
  logic             act_q, act_d;
  logic             sig_q, sig_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [7:0]       mon_q, mon_d;

  logic             boundary;
  logic             mode_in_valid;
  logic [CNT_W-1:0] p_in_len, s_in_len, p_q_len, s_q_len;

  // Zero-length phases are stretched to one clock. The *_in lengths are
  // used where the inputs are being latched on this same edge.
  assign p_in_len = (precharge_n == '0) ? CNT_ONE : precharge_n;
  assign s_in_len = (sample_n    == '0) ? CNT_ONE : sample_n;
  assign p_q_len  = (pn_q        == '0) ? CNT_ONE : pn_q;
  assign s_q_len  = (sn_q        == '0) ? CNT_ONE : sn_q;
  assign mode_in_valid = (mode == MODE_NO_AZ) || (mode == MODE_AZ);

  // Next-state process
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    pn_d     = pn_q;
    sn_d     = sn_q;
    azv_d    = azv_q;
    cyc_d    = cyc_q;
    led_d    = led_q;
    boundary = 1'b0;

    case (state_q)
      IDLE: begin
        if (run && mode_in_valid) begin
          mode_d  = mode;
          pn_d    = precharge_n;
          sn_d    = sample_n;
          azv_d   = az_mux_val;
          state_d = PC_BOOT;
          cnt_d   = p_in_len;
        end
      end
      PC_BOOT: begin
        if (cnt_q == CNT_ONE) begin
          state_d = SAMPLE_SIG;
          cnt_d   = s_q_len;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      SAMPLE_SIG: begin
        if (cnt_q == CNT_ONE) begin
          if (mode_q == MODE_AZ) begin
            state_d = PC_RESTORE;
            cnt_d   = p_q_len;
          end else begin
            boundary = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      PC_RESTORE: begin
        if (cnt_q == CNT_ONE) begin
          state_d = SAMPLE_LO;
          cnt_d   = s_q_len;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      SAMPLE_LO: begin
        if (cnt_q == CNT_ONE) begin
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // End of a full cycle: count it, re-latch, then pick the next phase.
    if (boundary) begin
      cyc_d  = cyc_q + CYC_W'(1);
      led_d  = ~led_q;
      mode_d = mode;
      pn_d   = precharge_n;
      sn_d   = sample_n;
      azv_d  = az_mux_val;
      if (!run || !mode_in_valid) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if ((mode == mode_q) && (mode == MODE_NO_AZ)) begin
        // Same NO_AZ mode: windows run back to back, no boot phase.
        state_d = SAMPLE_SIG;
        cnt_d   = s_in_len;
      end else begin
        state_d = PC_BOOT;
        cnt_d   = p_in_len;
      end
    end
  end

  // Output values are derived from the next state so that they change on
  // the same edge that enters a phase.
  always_comb begin
    sw_d    = 1'b0;
    azmux_d = PC_MUX_VAL;
    act_d   = 1'b0;
    sig_d   = sig_q;
    case (state_d)
      IDLE: begin
        azmux_d = '0;
      end
      PC_BOOT, PC_RESTORE: begin
        azmux_d = PC_MUX_VAL;
      end
      SAMPLE_SIG: begin
        sw_d  = 1'b1;
        act_d = 1'b1;
        sig_d = 1'b1;
      end
      SAMPLE_LO: begin
        azmux_d = azv_d;
        act_d   = 1'b1;
        sig_d   = 1'b0;
      end
      default: begin
        azmux_d = '0;
      end
    endcase
    done_d = act_d && (cnt_d == CNT_ONE);
    busy_d = (state_d != IDLE);
    mon_d  = {busy_d, state_d, done_d, sw_d, act_d & ~sig_d, act_d & sig_d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 2'b00;
      pn_q    <= '0;
      sn_q    <= '0;
      azv_q   <= '0;
      cyc_q   <= '0;
      led_q   <= 1'b0;
      sw_q    <= 1'b0;
      azmux_q <= '0;
      act_q   <= 1'b0;
      sig_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      mon_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      pn_q    <= pn_d;
      sn_q    <= sn_d;
      azv_q   <= azv_d;
      cyc_q   <= cyc_d;
      led_q   <= led_d;
      sw_q    <= sw_d;
      azmux_q <= azmux_d;
      act_q   <= act_d;
      sig_q   <= sig_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      mon_q   <= mon_d;
    end
  end

  assign sw_pc_ctl     = sw_q;
  assign azmux         = azmux_q;
  assign sample_active = act_q;
  assign sample_is_sig = sig_q;
  assign sample_done   = done_q;
  assign busy          = busy_q;
  assign cycle_count   = cyc_q;
  assign led0          = led_q;
  assign monitor       = mon_q;

endmodule

// File: tb/tb_modulation_az_seq.sv
module tb_modulation_az_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [23:0] precharge_n = '0;
  logic [23:0] sample_n = '0;
  logic [3:0]  az_mux_val = '0;
  logic        sw_pc_ctl;
  logic [3:0]  azmux;
  logic        sample_active;
  logic        sample_is_sig;
  logic        sample_done;
  logic        busy;
  logic [15:0] cycle_count;
  logic        led0;
  logic [7:0]  monitor;

  int checks = 0;
  int errors = 0;

  // Clock
  always #5 clk = ~clk;

  modulation_az_seq dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .mode          (mode),
    .precharge_n   (precharge_n),
    .sample_n      (sample_n),
    .az_mux_val    (az_mux_val),
    .sw_pc_ctl     (sw_pc_ctl),
    .azmux         (azmux),
    .sample_active (sample_active),
    .sample_is_sig (sample_is_sig),
    .sample_done   (sample_done),
    .busy          (busy),
    .cycle_count   (cycle_count),
    .led0          (led0),
    .monitor       (monitor)
  );

  // Advance n clocks, ending 1 time unit after the rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic [15:0] exp_cnt);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " sw"}, 32'(sw_pc_ctl), 32'd0);
    check({tag, " azmux"}, 32'(azmux), 32'd0);
    check({tag, " active"}, 32'(sample_active), 32'd0);
    check({tag, " count"}, 32'(cycle_count), 32'(exp_cnt));
    check({tag, " led0"}, 32'(led0), 32'(exp_cnt[0]));
  endtask

  initial begin
    logic exp_sw, exp_act, exp_done;
    logic [3:0] exp_mux;

    // Reset state
    step(2);
    check_idle("reset", 16'd0);
    check("reset monitor", 32'(monitor), 32'h00);
    reset = 1'b0;
    step(1);
    check_idle("post-reset idle", 16'd0);

    // AZ, P=3, S=5, az_mux_val=0011: 16-clock period
    mode = 2'b10; precharge_n = 24'd3; sample_n = 24'd5; az_mux_val = 4'b0011; run = 1'b1;
    step(1);
    for (int k = 0; k < 16; k++) begin
      exp_sw   = (k >= 3) && (k < 8);
      exp_mux  = (k < 11) ? 4'b1000 : 4'b0011;
      exp_act  = ((k >= 3) && (k < 8)) || (k >= 11);
      exp_done = (k == 7) || (k == 15);
      check($sformatf("az off%0d sw", k), 32'(sw_pc_ctl), 32'(exp_sw));
      check($sformatf("az off%0d azmux", k), 32'(azmux), 32'(exp_mux));
      check($sformatf("az off%0d active", k), 32'(sample_active), 32'(exp_act));
      check($sformatf("az off%0d done", k), 32'(sample_done), 32'(exp_done));
      check($sformatf("az off%0d busy", k), 32'(busy), 32'd1);
      if (k == 3)  check("az monitor sig", 32'(monitor), 32'hA5);
      if (k == 15) check("az monitor lo", 32'(monitor), 32'hCA);
      if (k == 15) check("az count before boundary", 32'(cycle_count), 32'd0);
      step(1);
    end
    // Offset 16: second cycle starts in PC_BOOT
    check("az c1 count", 32'(cycle_count), 32'd1);
    check("az c1 led0", 32'(led0), 32'd1);
    check("az c2 sw", 32'(sw_pc_ctl), 32'd0);
    check("az c2 azmux", 32'(azmux), 32'h8);
    check("az c2 monitor", 32'(monitor), 32'h90);

    // Drop run at offset 9 (PC_RESTORE): full cycle still completes
    step(9);
    run = 1'b0;
    check("stop off9 sw", 32'(sw_pc_ctl), 32'd0);
    check("stop off9 busy", 32'(busy), 32'd1);
    step(6);
    check("stop off15 done", 32'(sample_done), 32'd1);
    check("stop off15 busy", 32'(busy), 32'd1);
    step(1);
    check_idle("stop idle", 16'd2);

    // NO_AZ, P=3, S=5: one boot then continuous signal windows
    mode = 2'b01; run = 1'b1;
    step(1);
    for (int k = 0; k < 23; k++) begin
      exp_sw   = (k >= 3);
      exp_done = (k >= 3) && (((k - 3) % 5) == 4);
      check($sformatf("noaz off%0d sw", k), 32'(sw_pc_ctl), 32'(exp_sw));
      check($sformatf("noaz off%0d active", k), 32'(sample_active), 32'(exp_sw));
      check($sformatf("noaz off%0d done", k), 32'(sample_done), 32'(exp_done));
      check($sformatf("noaz off%0d azmux", k), 32'(azmux), 32'h8);
      step(1);
    end
    check("noaz count", 32'(cycle_count), 32'd6);
    run = 1'b0;
    step(4);
    check("noaz stop off27 done", 32'(sample_done), 32'd1);
    step(1);
    check_idle("noaz idle", 16'd7);
    check("noaz idle sig flag", 32'(sample_is_sig), 32'd1);

    // Zero durations in AZ: 4-clock period
    mode = 2'b10; precharge_n = 24'd0; sample_n = 24'd0; run = 1'b1;
    step(1);
    for (int k = 0; k < 4; k++) begin
      exp_sw   = (k == 1);
      exp_mux  = (k == 3) ? 4'b0011 : 4'b1000;
      exp_done = (k == 1) || (k == 3);
      check($sformatf("zero off%0d sw", k), 32'(sw_pc_ctl), 32'(exp_sw));
      check($sformatf("zero off%0d azmux", k), 32'(azmux), 32'(exp_mux));
      check($sformatf("zero off%0d done", k), 32'(sample_done), 32'(exp_done));
      step(1);
    end
    check("zero c1 count", 32'(cycle_count), 32'd8);
    check("zero c2 azmux", 32'(azmux), 32'h8);
    run = 1'b0;
    step(4);
    check_idle("zero idle", 16'd9);

    // Mid-cycle sample_n 5->2 and mode 10->01
    mode = 2'b10; precharge_n = 24'd3; sample_n = 24'd5; run = 1'b1;
    step(1);
    for (int k = 0; k < 25; k++) begin
      exp_sw   = ((k >= 3) && (k < 8)) || (k >= 19);
      exp_act  = ((k >= 3) && (k < 8)) || ((k >= 11) && (k < 16)) || (k >= 19);
      exp_done = (k == 7) || (k == 15) || (k == 20) || (k == 22) || (k == 24);
      check($sformatf("chg off%0d sw", k), 32'(sw_pc_ctl), 32'(exp_sw));
      check($sformatf("chg off%0d active", k), 32'(sample_active), 32'(exp_act));
      check($sformatf("chg off%0d done", k), 32'(sample_done), 32'(exp_done));
      if (k == 16) check("chg boundary count", 32'(cycle_count), 32'd10);
      if (k == 16) check("chg boot azmux", 32'(azmux), 32'h8);
      if (k == 21) check("chg first noaz count", 32'(cycle_count), 32'd11);
      if (k == 2) begin
        sample_n = 24'd2;
        mode = 2'b01;
      end
      step(1);
    end

    // Async reset mid-SAMPLE_LO, then restart
    run = 1'b0;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    mode = 2'b10; precharge_n = 24'd3; sample_n = 24'd5; run = 1'b1;
    step(1);
    step(12);
    check("pre-reset lo azmux", 32'(azmux), 32'h3);
    check("pre-reset lo active", 32'(sample_active), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_idle("async reset", 16'd0);
    check("async reset monitor", 32'(monitor), 32'h00);
    reset = 1'b0;
    step(1);
    check("restart sw", 32'(sw_pc_ctl), 32'd0);
    check("restart azmux", 32'(azmux), 32'h8);
    check("restart busy", 32'(busy), 32'd1);
    check("restart monitor", 32'(monitor), 32'h90);
    check("restart count", 32'(cycle_count), 32'd0);

    // Mode 11 behaves as idle
    reset = 1'b1;
    #1 reset = 1'b0;
    mode = 2'b11; run = 1'b1;
    step(2);
    check_idle("mode11", 16'd0);
    check("mode11 monitor", 32'(monitor), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Overall time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
